// File: rtl/bp_be_accel_op_sched_pkg.sv
// bp_be_pkg: shared types for the BE accelerator issue scheduler.
//   bp_be_accel_op_e          committed tensor op encoding (bit 1 = weight load, bit 0 = half/slot)
//   bp_be_accel_sched_state_e weight-residency state of the scheduler FSM
//   bsg_safe_clog2            clog2 that never returns 0, for counter widths
package bp_be_pkg;

    typedef enum logic [1:0] {
        e_acld0 = 2'b00,
        e_acld1 = 2'b01,
        e_wtld0 = 2'b10,
        e_wtld1 = 2'b11
    } bp_be_accel_op_e;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_PART,
        S_READY,
        S_DRAIN
    } bp_be_accel_sched_state_e;

    function automatic int bsg_safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/bp_be_accel_op_sched_if.sv
// bp_be_accel_op_sched_if: op/data ingress and core issue bus of the scheduler.
//   op_i/op_v_i/op_ready_o         committed op channel
//   data_i/data_v_i/data_ready_o   wide dcache data channel (same order as ops)
//   core_op_o/core_data_o/core_v_o/core_ready_and_i  issue channel to the systolic core
//
// Handshake rule for every channel: a transfer happens on a rising clock edge
// where valid and ready are both high. Ready never depends on valid. Once the
// scheduler raises core_v_o it keeps it high with core_op_o/core_data_o stable
// until the transfer, unless a flush retracts it.
interface bp_be_accel_op_sched_if #(parameter int block_width_p = 512);

    logic [1:0]               op_i;
    logic                     op_v_i;
    logic                     op_ready_o;
    logic [block_width_p-1:0] data_i;
    logic                     data_v_i;
    logic                     data_ready_o;
    logic [1:0]               core_op_o;
    logic [block_width_p-1:0] core_data_o;
    logic                     core_v_o;
    logic                     core_ready_and_i;

    // scheduler side
    modport slave (
        input  op_i, op_v_i, data_i, data_v_i, core_ready_and_i,
        output op_ready_o, data_ready_o, core_op_o, core_data_o, core_v_o
    );

    // producer / core side
    modport master (
        output op_i, op_v_i, data_i, data_v_i, core_ready_and_i,
        input  op_ready_o, data_ready_o, core_op_o, core_data_o, core_v_o
    );

endinterface

// File: rtl/bp_be_accel_credit_ctr.sv
// bp_be_accel_credit_ctr: outstanding-activation counter (0..max_p).
//   clk_i, reset_i (async, active-high)
//   up_i        activation issued
//   down_i      result drained from writeback (credit return)
//   count_o     current number of outstanding activations
//   underflow_o pulses when a credit returns with nothing outstanding
module bp_be_accel_credit_ctr
    import bp_be_pkg::*;
#(
    parameter int max_p   = 2,
    parameter int width_p = bsg_safe_clog2(max_p + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               up_i,
    input  logic               down_i,
    output logic [width_p-1:0] count_o,
    output logic               underflow_o
);

    localparam logic [width_p-1:0] max_lp = width_p'(max_p);
    localparam logic [width_p-1:0] one_lp = width_p'(1);

    logic [width_p-1:0] count_r;

    assign count_o     = count_r;
    // a simultaneous issue pairs with the return, so it is not an underflow
    assign underflow_o = down_i & ~up_i & (count_r == '0);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_r <= '0;
        end else if (up_i & ~down_i & (count_r != max_lp)) begin
            count_r <= count_r + one_lp;
        end else if (down_i & ~up_i & (count_r != '0)) begin
            count_r <= count_r - one_lp;
        end
    end

endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// bsg_fifo_1r1w_small: small register-based FIFO.
//   clk_i, reset_i (async, active-high), clear_i (sync empty; wins over push)
//   v_i/data_i/ready_o  push side, ready_o = not full
//   v_o/data_o/yumi_i   pop side, data_o is the head, yumi_i pops it
module bsg_fifo_1r1w_small #(
    parameter int width_p = 8,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int ptr_w_lp = (els_p <= 1) ? 1 : $clog2(els_p);
    localparam int cnt_w_lp = $clog2(els_p + 1);
    localparam logic [cnt_w_lp-1:0] full_cnt_lp = cnt_w_lp'(els_p);
    localparam logic [cnt_w_lp-1:0] cnt_one_lp  = cnt_w_lp'(1);
    localparam logic [ptr_w_lp-1:0] last_ptr_lp = ptr_w_lp'(els_p - 1);
    localparam logic [ptr_w_lp-1:0] ptr_one_lp  = ptr_w_lp'(1);

    logic [width_p-1:0]  mem_r [els_p];
    logic [ptr_w_lp-1:0] rd_ptr_r, wr_ptr_r;
    logic [cnt_w_lp-1:0] cnt_r;
    logic                push, pop;

    assign ready_o = (cnt_r != full_cnt_lp);
    assign v_o     = (cnt_r != '0);
    assign data_o  = mem_r[rd_ptr_r];
    assign push    = v_i & ready_o & ~clear_i;
    assign pop     = yumi_i & v_o & ~clear_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            cnt_r    <= '0;
        end else if (clear_i) begin
            rd_ptr_r <= '0;
            wr_ptr_r <= '0;
            cnt_r    <= '0;
        end else begin
            if (push) wr_ptr_r <= (wr_ptr_r == last_ptr_lp) ? '0 : wr_ptr_r + ptr_one_lp;
            if (pop)  rd_ptr_r <= (rd_ptr_r == last_ptr_lp) ? '0 : rd_ptr_r + ptr_one_lp;
            case ({push, pop})
                2'b10:   cnt_r <= cnt_r + cnt_one_lp;
                2'b01:   cnt_r <= cnt_r - cnt_one_lp;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // storage is not reset; entries are only read once counted valid
    always_ff @(posedge clk_i) begin
        if (push) mem_r[wr_ptr_r] <= data_i;
    end

endmodule

// File: rtl/bp_be_accel_op_sched.sv
// bp_be_accel_op_sched: issue scheduler for the weight-stationary tensor core.
// Pairs committed ops with their wide data blocks, orders weight loads against
// in-flight activations, and throttles activations by writeback credits.
//   clk_i, reset_n_i   clock, async active-low reset
//   io (slave)         op/data ingress and core issue handshake
//   result_done_i      one pulse per drained result (credit return)
//   flush_i            synchronous abort: empties queues, state -> S_EMPTY, clears errors
//   busy_o             any queue non-empty or activations outstanding
//   error_o            sticky [0] ACLD without weights, [1] credit underflow
//   state_o, w_v_o, inflight_o  FSM state, weight-half valids, outstanding count
module bp_be_accel_op_sched
    import bp_be_pkg::*;
#(
    parameter int block_width_p = 512,
    parameter int q_els_p       = 2,
    parameter int credits_p     = 2,
    parameter int credit_w_lp   = bsg_safe_clog2(credits_p + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    bp_be_accel_op_sched_if.slave    io,
    input  logic                     result_done_i,
    input  logic                     flush_i,
    output logic                     busy_o,
    output logic [1:0]               error_o,
    output bp_be_accel_sched_state_e state_o,
    output logic [1:0]               w_v_o,
    output logic [credit_w_lp-1:0]   inflight_o
);

    localparam logic [credit_w_lp-1:0] credits_lp = credit_w_lp'(credits_p);

    logic reset_li;
    assign reset_li = ~reset_n_i;

    // queues
    logic                     op_q_v, op_q_ready, data_q_v, data_q_ready;
    logic [1:0]               op_q_head;
    logic [block_width_p-1:0] data_q_head;
    logic                     pop;

    bsg_fifo_1r1w_small #(.width_p(2), .els_p(q_els_p)) op_q (
        .clk_i   (clk_i),
        .reset_i (reset_li),
        .clear_i (flush_i),
        .v_i     (io.op_v_i),
        .data_i  (io.op_i),
        .ready_o (op_q_ready),
        .v_o     (op_q_v),
        .data_o  (op_q_head),
        .yumi_i  (pop)
    );

    bsg_fifo_1r1w_small #(.width_p(block_width_p), .els_p(q_els_p)) data_q (
        .clk_i   (clk_i),
        .reset_i (reset_li),
        .clear_i (flush_i),
        .v_i     (io.data_v_i),
        .data_i  (io.data_i),
        .ready_o (data_q_ready),
        .v_o     (data_q_v),
        .data_o  (data_q_head),
        .yumi_i  (pop)
    );

    // credits
    logic [credit_w_lp-1:0] inflight;
    logic                   acld_fire, underflow;

    bp_be_accel_credit_ctr #(.max_p(credits_p), .width_p(credit_w_lp)) credit_ctr (
        .clk_i       (clk_i),
        .reset_i     (reset_li),
        .up_i        (acld_fire),
        .down_i      (result_done_i),
        .count_o     (inflight),
        .underflow_o (underflow)
    );

    // FSM
    bp_be_accel_sched_state_e state_r, state_n;
    logic [1:0]               w_v_r, w_v_n;
    logic [1:0]               error_r;
    logic                     head_v, core_v, drop_err, k;
    bp_be_accel_op_e          head_op;

    assign head_v  = op_q_v & data_q_v;
    assign head_op = bp_be_accel_op_e'(op_q_head);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= S_EMPTY;
            w_v_r   <= '0;
            error_r <= '0;
        end else begin
            state_r <= state_n;
            w_v_r   <= w_v_n;
            error_r <= flush_i ? 2'b00 : (error_r | {underflow, drop_err});
        end
    end

    always_comb begin
        state_n   = state_r;
        w_v_n     = w_v_r;
        core_v    = 1'b0;
        pop       = 1'b0;
        drop_err  = 1'b0;
        acld_fire = 1'b0;
        k         = head_op[0];
        if (head_v && !flush_i) begin
            if (head_op[1]) begin
                // weight load into half k
                case (state_r)
                    S_EMPTY, S_PART: begin
                        core_v = 1'b1;
                        if (io.core_ready_and_i) begin
                            pop      = 1'b1;
                            w_v_n[k] = 1'b1;
                            state_n  = (w_v_n == 2'b11) ? S_READY : S_PART;
                        end
                    end
                    default: begin
                        // a full reload must not overwrite weights still used by
                        // outstanding activations
                        if (inflight == '0) begin
                            core_v = 1'b1;
                            if (io.core_ready_and_i) begin
                                pop      = 1'b1;
                                w_v_n    = 2'b00;
                                w_v_n[k] = 1'b1;
                                state_n  = S_PART;
                            end
                        end else begin
                            state_n = S_DRAIN;
                        end
                    end
                endcase
            end else if (state_r == S_READY) begin
                if (inflight < credits_lp) begin
                    core_v = 1'b1;
                    if (io.core_ready_and_i) begin
                        pop       = 1'b1;
                        acld_fire = 1'b1;
                    end
                end
            end else begin
                // activation without resident weights: discard the pair
                pop      = 1'b1;
                drop_err = 1'b1;
            end
        end
        if (flush_i) begin
            state_n = S_EMPTY;
            w_v_n   = 2'b00;
        end
    end

    assign io.op_ready_o   = op_q_ready;
    assign io.data_ready_o = data_q_ready;
    assign io.core_v_o     = core_v;
    assign io.core_op_o    = op_q_head;
    assign io.core_data_o  = data_q_head;

    assign busy_o     = op_q_v | data_q_v | (inflight != '0);
    assign error_o    = error_r;
    assign state_o    = state_r;
    assign w_v_o      = w_v_r;
    assign inflight_o = inflight;

endmodule

// File: tb/tb_bp_be_accel_op_sched.sv
module tb_bp_be_accel_op_sched;
    import bp_be_pkg::*;

    localparam int BW = 512;
    localparam int W  = BW + 2;

    // clock / reset
    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic                     reset_n_i;
    logic                     result_done_i;
    logic                     flush_i;
    logic                     busy_o;
    logic [1:0]               error_o;
    bp_be_accel_sched_state_e state_o;
    logic [1:0]               w_v_o;
    logic [1:0]               inflight_o;

    bp_be_accel_op_sched_if #(.block_width_p(BW)) io();

    bp_be_accel_op_sched #(.block_width_p(BW), .q_els_p(2), .credits_p(2)) dut (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .io            (io),
        .result_done_i (result_done_i),
        .flush_i       (flush_i),
        .busy_o        (busy_o),
        .error_o       (error_o),
        .state_o       (state_o),
        .w_v_o         (w_v_o),
        .inflight_o    (inflight_o)
    );

    // scoreboard
    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] mk_d(input int n);
        logic [31:0] w;
        w = 32'hDA7A_0000 + n;
        return {16{w}};
    endfunction

    // every issue handshake must match the next expected (op, data)
    always @(negedge clk_i) begin
        logic [W-1:0] e;
        #4;
        if (reset_n_i && io.core_v_o && io.core_ready_and_i) begin
            if (exp_q.size() == 0) begin
                check_eq("issue_pending", BW'(exp_q.size()), BW'(1));
            end else begin
                e = exp_q.pop_front();
                check_eq("issue_op", BW'(io.core_op_o), BW'(e[W-1:BW]));
                check_eq("issue_data", io.core_data_o, e[BW-1:0]);
            end
        end
    end

    // driver tasks
    task automatic drive(input logic ov, input logic [1:0] o, input logic dv, input logic [BW-1:0] d);
        io.op_v_i   = ov;
        io.op_i     = o;
        io.data_v_i = dv;
        io.data_i   = d;
    endtask

    task automatic send(input logic [1:0] o, input logic [BW-1:0] d);
        int n;
        n = 0;
        @(negedge clk_i);
        drive(1'b0, 2'b00, 1'b0, '0);
        while (!(io.op_ready_o && io.data_ready_o) && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 20) check_eq("send_timeout", BW'(n), BW'(0));
        drive(1'b1, o, 1'b1, d);
        exp_q.push_back({o, d});
    endtask

    task automatic idle();
        @(negedge clk_i);
        drive(1'b0, 2'b00, 1'b0, '0);
    endtask

    task automatic pulse_done();
        @(negedge clk_i);
        result_done_i = 1'b1;
        @(negedge clk_i);
        result_done_i = 1'b0;
    endtask

    initial begin
        reset_n_i           = 1'b0;
        result_done_i       = 1'b0;
        flush_i             = 1'b0;
        io.core_ready_and_i = 1'b0;
        drive(1'b0, 2'b00, 1'b0, '0);
        repeat (2) @(negedge clk_i);
        #1;
        check_eq("rst_core_v", BW'(io.core_v_o), BW'(0));
        check_eq("rst_busy", BW'(busy_o), BW'(0));
        check_eq("rst_op_ready", BW'(io.op_ready_o), BW'(1));
        check_eq("rst_data_ready", BW'(io.data_ready_o), BW'(1));
        check_eq("rst_error", BW'(error_o), BW'(0));
        check_eq("rst_state", BW'(state_o), BW'(S_EMPTY));
        check_eq("rst_inflight", BW'(inflight_o), BW'(0));
        @(negedge clk_i);
        reset_n_i           = 1'b1;
        io.core_ready_and_i = 1'b1;

        // 1: WTLD0, WTLD1, ACLD0 back to back
        @(negedge clk_i);
        drive(1'b1, 2'd2, 1'b1, mk_d(0)); exp_q.push_back({2'd2, mk_d(0)});
        #1 check_eq("t1_c0_v", BW'(io.core_v_o), BW'(0));
        @(negedge clk_i);
        drive(1'b1, 2'd3, 1'b1, mk_d(1)); exp_q.push_back({2'd3, mk_d(1)});
        #1;
        check_eq("t1_c1_v", BW'(io.core_v_o), BW'(1));
        check_eq("t1_c1_op", BW'(io.core_op_o), BW'(2));
        check_eq("t1_c1_state", BW'(state_o), BW'(S_EMPTY));
        @(negedge clk_i);
        drive(1'b1, 2'd0, 1'b1, mk_d(2)); exp_q.push_back({2'd0, mk_d(2)});
        #1;
        check_eq("t1_c2_op", BW'(io.core_op_o), BW'(3));
        check_eq("t1_c2_state", BW'(state_o), BW'(S_PART));
        check_eq("t1_c2_wv", BW'(w_v_o), BW'(2'b01));
        @(negedge clk_i);
        drive(1'b0, 2'd0, 1'b0, '0);
        #1;
        check_eq("t1_c3_v", BW'(io.core_v_o), BW'(1));
        check_eq("t1_c3_op", BW'(io.core_op_o), BW'(0));
        check_eq("t1_c3_state", BW'(state_o), BW'(S_READY));
        @(negedge clk_i);
        #1;
        check_eq("t1_end_v", BW'(io.core_v_o), BW'(0));
        check_eq("t1_inflight", BW'(inflight_o), BW'(1));
        check_eq("t1_busy", BW'(busy_o), BW'(1));

        // 2: ACLD without weights is dropped and flagged
        @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i       = 1'b0;
        result_done_i = 1'b1;
        drive(1'b1, 2'd0, 1'b1, mk_d(3));
        #1;
        check_eq("t2_state", BW'(state_o), BW'(S_EMPTY));
        check_eq("t2_wv", BW'(w_v_o), BW'(0));
        check_eq("t2_inflight_kept", BW'(inflight_o), BW'(1));
        @(negedge clk_i);
        result_done_i = 1'b0;
        drive(1'b0, 2'd0, 1'b0, '0);
        #1;
        check_eq("t2_drop_v", BW'(io.core_v_o), BW'(0));
        check_eq("t2_inflight0", BW'(inflight_o), BW'(0));
        @(negedge clk_i);
        #1;
        check_eq("t2_error", BW'(error_o), BW'(2'b01));
        check_eq("t2_popped", BW'(busy_o), BW'(0));
        @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        #1 check_eq("t2_flush_err", BW'(error_o), BW'(0));

        // 3: credit throttling
        send(2'd2, mk_d(4));
        send(2'd3, mk_d(5));
        send(2'd0, mk_d(6));
        send(2'd1, mk_d(7));
        send(2'd0, mk_d(8));
        idle();
        repeat (2) @(negedge clk_i);
        #1;
        check_eq("t3_stall_v", BW'(io.core_v_o), BW'(0));
        check_eq("t3_stall_op", BW'(io.core_op_o), BW'(0));
        check_eq("t3_inflight2", BW'(inflight_o), BW'(2));
        check_eq("t3_state", BW'(state_o), BW'(S_READY));
        check_eq("t3_pending", BW'(exp_q.size()), BW'(1));
        @(negedge clk_i);
        result_done_i = 1'b1;
        #1 check_eq("t3_done_cyc_v", BW'(io.core_v_o), BW'(0));
        @(negedge clk_i);
        result_done_i = 1'b0;
        #1;
        check_eq("t3_issue_v", BW'(io.core_v_o), BW'(1));
        check_eq("t3_inflight1", BW'(inflight_o), BW'(1));
        @(negedge clk_i);
        #1;
        check_eq("t3_after_inflight", BW'(inflight_o), BW'(2));
        check_eq("t3_after_v", BW'(io.core_v_o), BW'(0));
        check_eq("t3_drained_q", BW'(exp_q.size()), BW'(0));

        // 4: weight reload waits for in-flight activations
        @(negedge clk_i);
        result_done_i = 1'b1;
        drive(1'b1, 2'd2, 1'b1, mk_d(9)); exp_q.push_back({2'd2, mk_d(9)});
        @(negedge clk_i);
        result_done_i = 1'b0;
        drive(1'b0, 2'd0, 1'b0, '0);
        #1;
        check_eq("t4_hold_v", BW'(io.core_v_o), BW'(0));
        check_eq("t4_inflight1", BW'(inflight_o), BW'(1));
        @(negedge clk_i);
        #1;
        check_eq("t4_drain_state", BW'(state_o), BW'(S_DRAIN));
        check_eq("t4_drain_v", BW'(io.core_v_o), BW'(0));
        @(negedge clk_i);
        result_done_i = 1'b1;
        #1 check_eq("t4_done_cyc_v", BW'(io.core_v_o), BW'(0));
        @(negedge clk_i);
        result_done_i = 1'b0;
        #1;
        check_eq("t4_issue_v", BW'(io.core_v_o), BW'(1));
        check_eq("t4_issue_op", BW'(io.core_op_o), BW'(2));
        check_eq("t4_inflight0", BW'(inflight_o), BW'(0));
        @(negedge clk_i);
        #1;
        check_eq("t4_state", BW'(state_o), BW'(S_PART));
        check_eq("t4_wv", BW'(w_v_o), BW'(2'b01));

        // 5: ops ahead of data; queue-full back-pressure
        @(negedge clk_i);
        drive(1'b1, 2'd3, 1'b0, '0); exp_q.push_back({2'd3, mk_d(10)});
        @(negedge clk_i);
        drive(1'b1, 2'd0, 1'b0, '0); exp_q.push_back({2'd0, mk_d(11)});
        #1 check_eq("t5_op_ready_1", BW'(io.op_ready_o), BW'(1));
        @(negedge clk_i);
        drive(1'b0, 2'd0, 1'b0, '0);
        #1;
        check_eq("t5_op_full", BW'(io.op_ready_o), BW'(0));
        check_eq("t5_data_ready", BW'(io.data_ready_o), BW'(1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            #1 check_eq("t5_wait_v", BW'(io.core_v_o), BW'(0));
        end
        @(negedge clk_i);
        drive(1'b0, 2'd0, 1'b1, mk_d(10));
        @(negedge clk_i);
        drive(1'b0, 2'd0, 1'b1, mk_d(11));
        #1;
        check_eq("t5_w1_v", BW'(io.core_v_o), BW'(1));
        check_eq("t5_w1_op", BW'(io.core_op_o), BW'(3));
        @(negedge clk_i);
        drive(1'b0, 2'd0, 1'b0, '0);
        #1;
        check_eq("t5_a0_v", BW'(io.core_v_o), BW'(1));
        check_eq("t5_a0_op", BW'(io.core_op_o), BW'(0));
        check_eq("t5_ready_state", BW'(state_o), BW'(S_READY));
        @(negedge clk_i);
        #1;
        check_eq("t5_inflight", BW'(inflight_o), BW'(1));
        check_eq("t5_op_ready_back", BW'(io.op_ready_o), BW'(1));
        @(negedge clk_i);
        drive(1'b0, 2'd0, 1'b1, mk_d(20));
        @(negedge clk_i);
        drive(1'b0, 2'd0, 1'b1, mk_d(21));
        #1 check_eq("t5_data_ready_1", BW'(io.data_ready_o), BW'(1));
        @(negedge clk_i);
        drive(1'b0, 2'd0, 1'b0, '0);
        #1;
        check_eq("t5_data_full", BW'(io.data_ready_o), BW'(0));
        check_eq("t5_data_only_v", BW'(io.core_v_o), BW'(0));
        @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        #1;
        check_eq("t5_flush_ready", BW'(io.data_ready_o), BW'(1));
        check_eq("t5_flush_state", BW'(state_o), BW'(S_EMPTY));
        check_eq("t5_flush_busy", BW'(busy_o), BW'(1));

        // 6: credit underflow, then async reset while an issue is held
        pulse_done();
        #1;
        check_eq("t6_inflight0", BW'(inflight_o), BW'(0));
        check_eq("t6_err_clean", BW'(error_o), BW'(0));
        pulse_done();
        #1;
        check_eq("t6_underflow", BW'(error_o), BW'(2'b10));
        check_eq("t6_busy", BW'(busy_o), BW'(0));
        io.core_ready_and_i = 1'b0;
        send(2'd2, mk_d(12));
        idle();
        #1;
        check_eq("t6_hold_v", BW'(io.core_v_o), BW'(1));
        check_eq("t6_hold_op", BW'(io.core_op_o), BW'(2));
        @(negedge clk_i);
        #1;
        check_eq("t6_hold_v2", BW'(io.core_v_o), BW'(1));
        check_eq("t6_hold_data", io.core_data_o, mk_d(12));
        #2;
        reset_n_i = 1'b0;
        void'(exp_q.pop_back());
        #1;
        check_eq("t6_arst_v", BW'(io.core_v_o), BW'(0));
        check_eq("t6_arst_busy", BW'(busy_o), BW'(0));
        check_eq("t6_arst_op_ready", BW'(io.op_ready_o), BW'(1));
        check_eq("t6_arst_data_ready", BW'(io.data_ready_o), BW'(1));
        check_eq("t6_arst_error", BW'(error_o), BW'(0));
        check_eq("t6_arst_state", BW'(state_o), BW'(S_EMPTY));
        check_eq("t6_arst_wv", BW'(w_v_o), BW'(0));
        @(negedge clk_i);
        reset_n_i           = 1'b1;
        io.core_ready_and_i = 1'b1;
        pulse_done();
        #1 check_eq("t6_post_rst_underflow", BW'(error_o), BW'(2'b10));
        check_eq("final_exp_q_empty", BW'(exp_q.size()), BW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
